// File: rtl/tictactoe_pkg.sv
// tictactoe_pkg: shared cell, board and turn-FSM types for the TicTacToe datapath.
package tictactoe_pkg;

    typedef logic [1:0] celda_t;

    localparam celda_t VACIA = 2'b00;
    localparam celda_t J0    = 2'b01;
    localparam celda_t J1    = 2'b10;

    typedef logic [8:0][1:0] tablero_t;

    typedef enum logic [2:0] {SELECT, REQ, WAIT, CHECK, FIN} estado_t;

    function automatic logic [3:0] sig_celda(input logic [3:0] c);
        return (c == 4'd8) ? 4'd0 : c + 4'd1;
    endfunction

endpackage

// File: rtl/buscar_vacia.sv
// buscar_vacia: first empty cell scanning inicio, inicio+1, ... mod 9.
module buscar_vacia
    import tictactoe_pkg::*;
(
    input  tablero_t   tablero,
    input  logic [3:0] inicio,
    output logic [3:0] idx,
    output logic       hallado
);

    logic [3:0] c;

    always_comb begin
        idx     = inicio;
        hallado = 1'b0;
        c       = inicio;
        for (int i = 0; i < 9; i++) begin
            if (!hallado && tablero[c] == VACIA) begin
                idx     = c;
                hallado = 1'b1;
            end
            c = sig_celda(c);
        end
    end

endmodule

// File: rtl/control_jugadas.sv
// control_jugadas: turn FSM issuing placements to the board, with per-turn
// timeout auto-move, acknowledge timeout and win/draw detection.
module control_jugadas
    import tictactoe_pkg::*;
#(
    parameter int TURN_CYCLES = 50_000_000,
    parameter int ACK_TIMEOUT = 8,
    parameter int WIN_LAT     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_sig,
    input  logic        btn_ok,
    input  tablero_t    tablero,
    input  logic        win,
    input  logic        colocado,
    output logic [3:0]  pos,
    output logic        jugador,
    output logic        colocar,
    output logic [3:0]  cursor,
    output logic [31:0] tiempo,
    output logic        fin_juego,
    output logic        ganador,
    output logic        empate,
    output logic        err_ack
);

    localparam logic [31:0] T_MAX   = 32'(TURN_CYCLES - 1);
    localparam logic [3:0]  ACK_LIM = 4'(ACK_TIMEOUT - 1);
    localparam logic [3:0]  WIN_LIM = 4'(WIN_LAT - 1);

    estado_t    estado;
    logic [3:0] cnt;
    logic [3:0] auto_idx;
    logic       hay_vacia;
    logic       ok_valido;

    buscar_vacia u_buscar (
        .tablero (tablero),
        .inicio  (cursor),
        .idx     (auto_idx),
        .hallado (hay_vacia)
    );

    assign ok_valido = btn_ok && tablero[cursor] == VACIA;

    // cnt is shared: acknowledge wait in REQ, win latency in WAIT
    always_ff @(posedge clk) begin
        if (rst) begin
            estado    <= SELECT;
            pos       <= '0;
            cursor    <= '0;
            jugador   <= 1'b0;
            colocar   <= 1'b0;
            tiempo    <= T_MAX;
            fin_juego <= 1'b0;
            ganador   <= 1'b0;
            empate    <= 1'b0;
            err_ack   <= 1'b0;
            cnt       <= '0;
        end else begin
            err_ack <= 1'b0;
            case (estado)
                SELECT: begin
                    if (tiempo != '0)
                        tiempo <= tiempo - 32'd1;
                    if (ok_valido || (tiempo == '0 && hay_vacia)) begin
                        pos     <= ok_valido ? cursor : auto_idx;
                        colocar <= 1'b1;
                        cnt     <= '0;
                        estado  <= REQ;
                    end else if (btn_sig) begin
                        cursor <= sig_celda(cursor);
                    end
                end
                REQ: begin
                    if (colocado) begin
                        colocar <= 1'b0;
                        cnt     <= '0;
                        estado  <= WAIT;
                    end else if (cnt == ACK_LIM) begin
                        colocar <= 1'b0;
                        err_ack <= 1'b1;
                        estado  <= SELECT;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                WAIT: begin
                    if (cnt == WIN_LIM)
                        estado <= CHECK;
                    else
                        cnt <= cnt + 4'd1;
                end
                CHECK: begin
                    if (win) begin
                        fin_juego <= 1'b1;
                        ganador   <= jugador;
                        estado    <= FIN;
                    end else if (!hay_vacia) begin
                        fin_juego <= 1'b1;
                        empate    <= 1'b1;
                        estado    <= FIN;
                    end else begin
                        jugador <= ~jugador;
                        tiempo  <= T_MAX;
                        estado  <= SELECT;
                    end
                end
                FIN: begin
                    colocar   <= 1'b0;
                    fin_juego <= 1'b1;
                end
                default: estado <= SELECT;
            endcase
        end
    end

endmodule

// File: tb/tb_control_jugadas.sv
// tb_control_jugadas: random games against a game-rule reference; the bench
// plays the board and winner blocks itself.
module tb_control_jugadas;
    import tictactoe_pkg::*;

    localparam int TC = 10;
    localparam int AT = 8;
    localparam int WL = 2;

    logic        clk = 1'b0;
    logic        rst, btn_sig, btn_ok, win, colocado;
    tablero_t    tablero;
    logic [3:0]  pos, cursor;
    logic        jugador, colocar, fin_juego, ganador, empate, err_ack;
    logic [31:0] tiempo;

    int n_chk = 0;
    int n_err = 0;

    int m_cur, m_t, m_jug, m_pos;
    bit m_sel, m_fin;

    int lineas[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                         '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    always #5 clk = ~clk;

    control_jugadas #(.TURN_CYCLES(TC), .ACK_TIMEOUT(AT), .WIN_LAT(WL)) dut (
        .clk(clk), .rst(rst), .btn_sig(btn_sig), .btn_ok(btn_ok),
        .tablero(tablero), .win(win), .colocado(colocado),
        .pos(pos), .jugador(jugador), .colocar(colocar), .cursor(cursor),
        .tiempo(tiempo), .fin_juego(fin_juego), .ganador(ganador),
        .empate(empate), .err_ack(err_ack)
    );

    task automatic verificar(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit tres_en_linea();
        for (int i = 0; i < 8; i++)
            if (tablero[lineas[i][0]] != VACIA &&
                tablero[lineas[i][0]] == tablero[lineas[i][1]] &&
                tablero[lineas[i][1]] == tablero[lineas[i][2]])
                return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit lleno();
        for (int i = 0; i < 9; i++)
            if (tablero[i] == VACIA) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int primera_vacia(input int inicio);
        for (int k = 0; k < 9; k++)
            if (tablero[(inicio + k) % 9] == VACIA) return (inicio + k) % 9;
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        if (m_sel && m_t > 0) m_t--;
    endtask

    task automatic do_reset();
        rst = 1'b1; btn_sig = 1'b0; btn_ok = 1'b0; colocado = 1'b0; win = 1'b0;
        step();
        rst = 1'b0;
        m_cur = 0; m_t = TC - 1; m_jug = 0; m_sel = 1'b1; m_fin = 1'b0;
        verificar("rst_pos", pos, 0);
        verificar("rst_cursor", cursor, 0);
        verificar("rst_jugador", jugador, 0);
        verificar("rst_colocar", colocar, 0);
        verificar("rst_tiempo", tiempo, TC - 1);
        verificar("rst_fin", fin_juego, 0);
        verificar("rst_ganador", ganador, 0);
        verificar("rst_empate", empate, 0);
        verificar("rst_err_ack", err_ack, 0);
    endtask

    task automatic nuevo_juego();
        tablero = '0;
        do_reset();
    endtask

    task automatic pulsar_sig();
        btn_sig = 1'b1; step(); btn_sig = 1'b0;
        m_cur = (m_cur + 1) % 9;
        verificar("sig_cursor", cursor, m_cur);
        verificar("sig_tiempo", tiempo, m_t);
        verificar("sig_err_ack", err_ack, 0);
    endtask

    task automatic ir_a(input int tgt);
        int k = (tgt - m_cur + 9) % 9;
        for (int i = 0; i < k; i++) pulsar_sig();
    endtask

    task automatic pulsar_ok(output bit ok);
        ok = tablero[m_cur] == VACIA;
        btn_ok = 1'b1; step(); btn_ok = 1'b0;
        verificar("ok_colocar", colocar, int'(ok));
        verificar("ok_err_ack", err_ack, 0);
        if (ok) begin
            m_pos = m_cur;
            m_sel = 1'b0;
            verificar("ok_pos", pos, m_pos);
            verificar("ok_jugador", jugador, m_jug);
        end
    endtask

    task automatic esperar_auto();
        while (m_t > 0) begin
            step();
            verificar("auto_idle", colocar, 0);
        end
        m_pos = primera_vacia(m_cur);
        step();
        m_sel = 1'b0;
        verificar("auto_colocar", colocar, 1);
        verificar("auto_pos", pos, m_pos);
        verificar("auto_err_ack", err_ack, 0);
    endtask

    task automatic confirmar(input int d);
        bit w;
        for (int i = 0; i < d; i++) begin
            step();
            verificar("req_hold", colocar, 1);
            verificar("req_pos", pos, m_pos);
        end
        colocado = 1'b1; step(); colocado = 1'b0;
        verificar("ack_drop", colocar, 0);
        tablero[m_pos] = m_jug ? J1 : J0;
        w = tres_en_linea();
        step();
        win = w;
        step();
        verificar("check_lat", jugador, m_jug);
        step();
        if (w || lleno()) begin
            m_fin = 1'b1;
            verificar("fin_juego", fin_juego, 1);
            verificar("fin_empate", empate, int'(!w));
            if (w) verificar("fin_ganador", ganador, m_jug);
        end else begin
            m_jug ^= 1;
            m_t = TC - 1;
            m_sel = 1'b1;
            verificar("turn_jugador", jugador, m_jug);
            verificar("turn_tiempo", tiempo, m_t);
            verificar("turn_fin", fin_juego, 0);
        end
    endtask

    task automatic sin_confirmar();
        for (int i = 0; i < AT - 1; i++) begin
            step();
            verificar("to_hold", colocar, 1);
            verificar("to_err0", err_ack, 0);
        end
        step();
        m_sel = 1'b1;
        verificar("to_drop", colocar, 0);
        verificar("to_err", err_ack, 1);
        verificar("to_jugador", jugador, m_jug);
        verificar("to_tiempo", tiempo, m_t);
    endtask

    task automatic jugar(input int c, input int d);
        bit ok;
        ir_a(c);
        pulsar_ok(ok);
        if (ok) confirmar(d);
    endtask

    task automatic botones_fin();
        btn_ok = 1'b1; btn_sig = 1'b1; step(); btn_ok = 1'b0; btn_sig = 1'b0;
        verificar("fin_ignore_colocar", colocar, 0);
        verificar("fin_ignore_cursor", cursor, m_cur);
        verificar("fin_sticky", fin_juego, 1);
    endtask

    task automatic turno_aleatorio();
        bit hecho = 1'b0;
        while (!hecho) begin
            bit ok = 1'b0;
            while (!ok) begin
                int tgt = $urandom_range(8);
                int k = (tgt - m_cur + 9) % 9;
                if ($urandom_range(5) == 0 || m_t < k + 1) begin
                    esperar_auto();
                    ok = 1'b1;
                end else begin
                    ir_a(tgt);
                    pulsar_ok(ok);
                end
            end
            if ($urandom_range(6) == 0) begin
                sin_confirmar();
            end else begin
                confirmar($urandom_range(AT - 1));
                hecho = 1'b1;
            end
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        tablero = '0;
        nuevo_juego();
        pulsar_ok(ok);
        confirmar(0);

        nuevo_juego();
        tablero[4] = J1;
        ir_a(4);
        pulsar_ok(ok);
        pulsar_sig();
        pulsar_ok(ok);
        verificar("skip_occupied_pos", pos, 5);
        confirmar(3);

        nuevo_juego();
        tablero[7] = J0;
        tablero[8] = J1;
        ir_a(7);
        esperar_auto();
        verificar("auto_wrap_pos", pos, 0);
        sin_confirmar();
        esperar_auto();
        confirmar(AT - 1);

        nuevo_juego();
        pulsar_ok(ok);
        do_reset();

        nuevo_juego();
        jugar(3, 1); jugar(0, 2); jugar(4, 0); jugar(1, 5); jugar(5, 2);
        verificar("win_ganador", ganador, 0);
        botones_fin();

        nuevo_juego();
        foreach (lineas[i]) if (i == 0) begin
            jugar(0, 0); jugar(1, 1); jugar(2, 2); jugar(4, 3); jugar(3, 4);
            jugar(5, 5); jugar(7, 6); jugar(6, 7); jugar(8, 0);
        end
        verificar("draw_empate", empate, 1);
        do_reset();

        for (int g = 0; g < 20; g++) begin
            nuevo_juego();
            for (int t = 0; t < 9 && !m_fin; t++) turno_aleatorio();
            verificar("rand_fin", fin_juego, int'(m_fin));
            if (m_fin) botones_fin();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/control_jugadas.md
Name: control_jugadas

Overview:
- Move-issuing initiator for the TicTacToe board store. It is the requesting end of the board's placement interface (pos, jugador, colocar → colocado).
- Owns the turn FSM: cursor selection from buttons, a per-turn timeout with an automatic move, the placement handshake, alternation of players, and end-of-game detection.
- Uses the board contents and the win flag from the winner detector. Sits between the debounced button logic and the board/winner blocks.

Parameters:
- TURN_CYCLES, 50_000_000, clock cycles allowed per turn before an automatic move.
- ACK_TIMEOUT, 8, maximum cycles to wait for colocado after raising colocar.
- WIN_LAT, 2, cycles from the colocado pulse until win is valid (board register plus winner register).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- btn_sig  in  1  one-cycle pulse, already debounced: advance the cursor
- btn_ok  in  1  one-cycle pulse, already debounced: confirm the cell under the cursor
- tablero  in  [8:0][1:0]  board contents; 00 empty, 01 player 0, 10 player 1, 11 illegal (treated as occupied)
- win  in  1  winner detector flag
- colocado  in  1  board acknowledge, one-cycle pulse
- pos  out  4  requested cell 0..8
- jugador  out  1  current player
- colocar  out  1  placement request
- cursor  out  4  highlighted cell 0..8
- tiempo  out  32  cycles remaining in the turn
- fin_juego  out  1  game over
- ganador  out  1  valid when fin_juego=1 and empate=0
- empate  out  1  board full with no winner
- err_ack  out  1  one-cycle pulse on acknowledge timeout

Behaviour:
- Reset (synchronous, active-high): all outputs take these values on the next clk edge:
  - state=SELECT, pos=0, cursor=0, jugador=0, colocar=0
  - tiempo=TURN_CYCLES-1
  - fin_juego=0, ganador=0, empate=0, err_ack=0
  - rst overrides every state, including mid-handshake; colocar drops on the same edge.
- SELECT state:
  - tiempo decrements every cycle.
  - btn_sig: cursor wraps 8→0.
  - btn_ok on an empty cell: pos←cursor, go to REQ.
  - btn_ok on an occupied cell: ignored.
  - tiempo==0: pos←first empty cell scanning cursor, cursor+1, … mod 9; go to REQ.
  - btn_sig and btn_ok in the same cycle: btn_ok wins, using the pre-advance cursor.
- REQ state:
  - colocar=1; pos and jugador are held stable.
  - colocado seen: colocar←0 on the next edge, go to WAIT with a WIN_LAT counter.
  - No colocado within ACK_TIMEOUT cycles: colocar←0, err_ack pulses once, return to SELECT. jugador is unchanged and the timer is not reloaded.
  - colocado outside REQ is ignored.
- WAIT state: counts WIN_LAT cycles, then goes to CHECK.
- CHECK state (single cycle):
  - win=1 → FIN with ganador←jugador.
  - Otherwise all cells non-empty → FIN with empate←1.
  - Otherwise jugador toggles, tiempo←TURN_CYCLES-1, go to SELECT.
- FIN state:
  - fin_juego=1, colocar=0; all buttons ignored.
  - Sticky until rst.
- Latency: btn_ok → colocar high at the next edge. colocado → next-player SELECT after WIN_LAT+2 cycles.
- Widths:
  - pos and cursor never exceed 8.
  - tiempo is unsigned and never underflows (reload on a turn change; held at 0 only transiently).
- Board full in SELECT cannot occur, because CHECK catches it first.

Decomposition:
- Package tictactoe_pkg holds:
  - the cell typedef (2-bit) with VACIA, J0 and J1 constants
  - typedef tablero_t as [8:0][1:0]
  - the FSM state enum {SELECT, REQ, WAIT, CHECK, FIN}
- Natural sub-module: buscar_vacia, a combinational scanner taking tablero and a start index and returning the first empty index plus a found flag.

Test Plan:
- Reset with an empty board, btn_ok → colocar=1, pos=0, jugador=0. After a colocado pulse plus WIN_LAT+2 cycles: jugador=1, tiempo reloaded.
- Cell 4 occupied, cursor moved to 4 with 4× btn_sig, btn_ok → no colocar. One more btn_sig plus btn_ok → pos=5.
- TURN_CYCLES=10, cursor=7, cells 7 and 8 occupied, no buttons → after 10 cycles, auto move with pos=0.
- REQ state with colocado never asserted → colocar falls after ACK_TIMEOUT=8 cycles, err_ack pulses once, state returns to SELECT with jugador unchanged.
- Player 0 placements at 3, 4, 5 with win=1 after the third → fin_juego=1, ganador=0, empate=0. Later btn_ok is ignored.
- Draw sequence filling all 9 cells with win=0 → fin_juego=1, empate=1. Then rst in the next cycle → all outputs at reset values.
